alu4_ctrl: RTL and testbench

//  Sequential 4-bit two's-complement ALU front end for the board adder demo. Operands A and B
//  are entered one at a time on sw_data and committed by presses of one push-button. The

---
 rtl/alu4_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/alu4_ctrl.sv | 123 ++++++++++++
 tb/tb_alu4_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared types and constants for the 4-bit ALU front end
package alu4_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and single-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          prev_q;

  // The stable level resets to "pressed" so a button held through reset must
  // first be seen released before a rising edge can be accepted.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/alu4_ctrl.sv
// rtl/alu4_ctrl.sv - button-driven operand entry FSM with registered 4-bit ALU result and flags
module alu4_ctrl
  import alu4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [2:0]       sw_op,
  input  logic             btn_next,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             result_valid,
  output logic [1:0]       state_led
);

  logic press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .press   (press)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(sw_op))
      OP_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry here is the no-borrow flag of A + ~B + 1.
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~a_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a_q == b_q};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      LOAD_A: if (press) begin
        a_d     = sw_data;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        b_d     = sw_data;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res;
        carry_d  = alu_c;
        ovf_d    = alu_v;
        zero_d   = (alu_res == '0);
        state_d  = SHOW;
      end
      SHOW: if (press) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result       = result_q;
  assign carry        = carry_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;
  assign result_valid = (state_q == SHOW);
  assign state_led    = state_q;

endmodule

// File: tb/tb_alu4_ctrl.sv
// tb/tb_alu4_ctrl.sv - scoreboard bench for alu4_ctrl with a high-level arithmetic model
module tb_alu4_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_data = '0;
  logic [2:0] sw_op = '0;
  logic       btn_next = 1'b0;
  logic [3:0] result;
  logic       carry, overflow, zero, result_valid;
  logic [1:0] state_led;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [6:0] last_out = '0;
  logic       prev_valid = 1'b0;

  alu4_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_data      (sw_data),
    .sw_op        (sw_op),
    .btn_next     (btn_next),
    .result       (result),
    .carry        (carry),
    .overflow     (overflow),
    .zero         (zero),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Packed as {result, carry, overflow, zero}.
  function automatic logic [6:0] model(input int a, input int b, input int op);
    int sa, sb, r, full;
    logic c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin full = sa + sb; r = (a + b) % 16; c = (a + b) > 15; v = (full > 7) || (full < -8); end
      1: begin full = sa - sb; r = (a - b + 16) % 16; c = (a >= b); v = (full > 7) || (full < -8); end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (sa < sb) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return {r[3:0], c, v, (r == 0)};
  endfunction

  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("unexpected_show", 1, 0);
      else chk("alu_out", {result, carry, overflow, zero}, exp_q.pop_front());
    end
    prev_valid = result_valid;
  end

  task automatic press();
    btn_next = 1'b1;
    repeat (12) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n = 0;
    while (state_led != s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, state_led, s);
  endtask

  task automatic load_ab(input int a, input int b, input int op);
    wait_state(2'b00, "idle_load_a");
    sw_data = 4'(a);
    press();
    chk("hold_in_load_b", {result, carry, overflow, zero}, last_out);
    sw_data = 4'(b);
    sw_op = 3'(op);
  endtask

  task automatic run_op(input int a, input int b, input int op);
    logic [6:0] e;
    load_ab(a, b, op);
    e = model(a, b, op);
    exp_q.push_back(e);
    press();
    wait_state(2'b11, "reach_show");
    chk("valid_in_show", result_valid, 1);
    press();
    wait_state(2'b00, "back_to_load_a");
    chk("hold_in_load_a", {result, carry, overflow, zero}, e);
    last_out = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] e;
    #1;
    chk("reset_outputs", {result, carry, overflow, zero, result_valid, state_led}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    run_op(4'b0011, 4'b0100, 0);
    run_op(4'b0111, 4'b0001, 0);
    run_op(4'b0011, 4'b0101, 1);
    run_op(4'b1000, 4'b0001, 1);
    run_op(4'b1010, 4'b0110, 3);
    run_op(4'b1010, 4'b0110, 5);
    run_op(4'b1010, 4'b0110, 6);
    run_op(4'b1010, 4'b0110, 7);
    run_op(4'b1010, 4'b1010, 7);
    run_op(4'b1010, 4'b0110, 2);
    run_op(4'b1010, 4'b0110, 4);
    run_op(4'b0000, 4'b0000, 1);

    for (int i = 0; i < 16; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
    end

    // Reset while in EXEC, with a non-zero result currently held.
    run_op(4'b0011, 4'b0100, 0);
    load_ab(4'b0101, 4'b0001, 0);
    btn_next = 1'b1;
    wait_state(2'b10, "reach_exec");
    rst_n = 1'b0;
    #1;
    chk("reset_in_exec", {result, carry, overflow, zero, result_valid, state_led}, 0);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_out = '0;
    repeat (20) @(negedge clk);
    run_op(4'b0001, 4'b0001, 0);

    // Bounce then long hold: one advance, nothing on release.
    wait_state(2'b00, "bounce_idle");
    sw_data = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      repeat (2) @(negedge clk);
    end
    btn_next = 1'b1;
    repeat (100) @(negedge clk);
    chk("bounce_one_advance", state_led, 2'b01);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_release_no_advance", state_led, 2'b01);
    sw_data = 4'b0011;
    sw_op = 3'b001;
    e = model(6, 3, 1);
    exp_q.push_back(e);
    press();
    wait_state(2'b11, "bounce_show");
    press();
    wait_state(2'b00, "bounce_back");
    last_out = e;

    // Reset in SHOW with the button held through reset release.
    load_ab(4'b0010, 4'b0011, 0);
    exp_q.push_back(model(2, 3, 0));
    press();
    wait_state(2'b11, "show_before_reset");
    btn_next = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_show", {result, carry, overflow, zero, result_valid, state_led}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_through_reset", state_led, 2'b00);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    chk("release_after_reset", state_led, 2'b00);
    last_out = '0;
    run_op(4'b0101, 4'b0010, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
